// File: rtl/counter_reload_ctrl.sv
// counter_reload_ctrl
// Control stage that sits in front of a 4-bit loadable counter (rst > load > en).
// It buffers reload values in a small FIFO, issues a prescaled count enable, and
// reloads the counter from the FIFO each time the fed-back count reaches all-ones.
// If the FIFO is empty at terminal count, the last value taken from the FIFO is
// replayed and a sticky underrun flag is raised.
module counter_reload_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4,
  parameter int DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_en,
  output logic             tc_pulse,
  output logic             underrun,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [AW:0]      PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ZERO   = {(AW + 1){1'b0}};
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = {{(PW - 1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Reload FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             push_s;
  logic             pop_s;

  // Prescaler and strobe datapath.
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_s;
  logic             tc_s;
  logic             load_q, load_d;
  logic             en_q, en_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] cnt_d_q, cnt_d_d;
  logic [WIDTH-1:0] last_val_q, last_val_d;
  logic             underrun_q, underrun_d;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head_s  = mem_q[rd_ptr_q[AW-1:0]];
  assign cfg_ready    = rst & ~fifo_full_s;
  assign push_s       = cfg_valid & cfg_ready;

  // FIFO storage and pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ALL_ZEROS;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= cfg_data;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop always wins, start only counts from IDLE with data queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start && !fifo_empty_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Strobe decisions for the next cycle: initial load, prescaled enable or terminal-count reload.
  always_comb begin
    tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_MAX) && !stop;
    tc_s       = tick_s && (q_fb == ALL_ONES);
    pop_s      = !fifo_empty_s && (((state_q == ST_LOAD) && !stop) || tc_s);
    load_d     = ((state_q == ST_LOAD) && !stop) || tc_s;
    en_d       = tick_s && !tc_s;
    tc_d       = tc_s;
    cnt_d_d    = cnt_d_q;
    last_val_d = last_val_q;
    underrun_d = underrun_q;
    presc_d    = PRESC_ZERO;

    if (pop_s) begin
      cnt_d_d    = fifo_head_s;
      last_val_d = fifo_head_s;
    end else if (tc_s) begin
      cnt_d_d    = last_val_q;
      underrun_d = 1'b1;
    end else begin
      cnt_d_d    = cnt_d_q;
    end

    if ((state_q == ST_RUN) && !stop) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = PRESC_ZERO;
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end else begin
      presc_d = PRESC_ZERO;
    end
  end

  // Registered strobes, data and status; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q    <= PRESC_ZERO;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      tc_q       <= 1'b0;
      cnt_d_q    <= ALL_ZEROS;
      last_val_q <= ALL_ZEROS;
      underrun_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      load_q     <= load_d;
      en_q       <= en_d;
      tc_q       <= tc_d;
      cnt_d_q    <= cnt_d_d;
      last_val_q <= last_val_d;
      underrun_q <= underrun_d;
    end
  end

  assign cnt_load = load_q;
  assign cnt_en   = en_q;
  assign tc_pulse = tc_q;
  assign cnt_d    = cnt_d_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// Testbench for counter_reload_ctrl: table-driven directed vectors, hand-written
// corner sequences, then randomized stimulus checked against a behavioural model.
module tb_counter_reload_ctrl;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
  localparam int DEPTH    = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_valid;
  logic [3:0] cfg_data;
  logic       cfg_ready, cnt_load, cnt_en, tc_pulse, underrun, busy;
  logic [3:0] cnt_d;
  logic [3:0] q_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_reload_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .q_fb     (q_r),
    .cnt_load (cnt_load),
    .cnt_d    (cnt_d),
    .cnt_en   (cnt_en),
    .tc_pulse (tc_pulse),
    .underrun (underrun),
    .busy     (busy)
  );

  // The loadable counter being controlled: rst > load > en.
  always @(posedge clk) begin
    if (!rst) q_r <= 4'd0;
    else if (cnt_load) q_r <= cnt_d;
    else if (cnt_en) q_r <= q_r + 4'd1;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_data = 4'd0;
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_mode;   // 0 idle, 1 loading, 2 running
  int         m_phase;  // clocks spent in the current prescale period
  logic [3:0] m_fifo[$];
  logic [3:0] m_last, m_d;
  logic       m_und, m_load, m_en, m_tc;

  task automatic model_clock(input logic r, input logic st, input logic sp,
                             input logic cv, input logic [3:0] cd, input logic [3:0] q);
    bit can_push;
    if (!r) begin
      m_mode = 0; m_phase = 0; m_fifo.delete();
      m_last = 4'd0; m_d = 4'd0; m_und = 1'b0;
      m_load = 1'b0; m_en = 1'b0; m_tc = 1'b0;
    end else begin
      can_push = cv && (m_fifo.size() < DEPTH);
      m_load = 1'b0; m_en = 1'b0; m_tc = 1'b0;
      if (sp) begin
        m_mode = 0; m_phase = 0;
      end else if (m_mode == 0) begin
        if (st && m_fifo.size() > 0) m_mode = 1;
      end else if (m_mode == 1) begin
        m_d = m_fifo.pop_front(); m_last = m_d; m_load = 1'b1;
        m_mode = 2; m_phase = 0;
      end else begin
        if (m_phase == PRESCALE - 1) begin
          m_phase = 0;
          if (q == 4'hF) begin
            m_load = 1'b1; m_tc = 1'b1;
            if (m_fifo.size() > 0) begin
              m_d = m_fifo.pop_front(); m_last = m_d;
            end else begin
              m_d = m_last; m_und = 1'b1;
            end
          end else begin
            m_en = 1'b1;
          end
        end else begin
          m_phase++;
        end
      end
      if (can_push) m_fifo.push_back(cd);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r, st, sp, cv;
    logic [3:0] cd;
    logic rdy, ld, en;
    logic [3:0] d;
    logic tc, und, bz;
  } vec_t;

  function automatic vec_t mkv(logic r, logic st, logic sp, logic cv, logic [3:0] cd,
                               logic rdy, logic ld, logic en, logic [3:0] d,
                               logic tc, logic und, logic bz);
    vec_t v;
    v.r = r; v.st = st; v.sp = sp; v.cv = cv; v.cd = cd;
    v.rdy = rdy; v.ld = ld; v.en = en; v.d = d; v.tc = tc; v.und = und; v.bz = bz;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int en_cnt;
    bit seen;
    logic any_strobe;

    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b1; cfg_data = 4'h5;

    //              r     st    sp    cv    cd     rdy   ld    en    d      tc    und   bz
    tbl[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i < 18; i++)
      tbl[i] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    tbl[10] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    tbl[14] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    tbl[18] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1);
    tbl[19] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);

    // Reset, fill the FIFO, start, count D->E->F, reload from FIFO at F.
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].r; start = tbl[i].st; stop = tbl[i].sp;
      cfg_valid = tbl[i].cv; cfg_data = tbl[i].cd;
      #1;
      chk1($sformatf("v%0d_ready", i), cfg_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d_load", i), cnt_load, tbl[i].ld);
      chk1($sformatf("v%0d_en", i), cnt_en, tbl[i].en);
      chk4($sformatf("v%0d_d", i), cnt_d, tbl[i].d);
      chk1($sformatf("v%0d_tc", i), tc_pulse, tbl[i].tc);
      chk1($sformatf("v%0d_underrun", i), underrun, tbl[i].und);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].bz);
    end

    // FIFO drained: count 2..F, then terminal count replays last value with underrun.
    idle_inputs();
    en_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      chk1("s4_exclusive", cnt_load & cnt_en, 1'b0);
      if (cnt_en) en_cnt++;
      if (cnt_load) seen = 1'b1;
    end
    chk1("s4_tc_seen", seen, 1'b1);
    chki("s4_en_pulses", en_cnt, 13);
    chk4("s4_reload_d", cnt_d, 4'h2);
    chk1("s4_tc_pulse", tc_pulse, 1'b1);
    chk1("s4_en_at_tc", cnt_en, 1'b0);
    chk1("s4_underrun", underrun, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk1("s4_underrun_sticky", underrun, 1'b1);

    // stop to IDLE, push one value, then start+stop together stays IDLE.
    stop = 1'b1;
    tick();
    chk1("s5_stop_busy", busy, 1'b0);
    stop = 1'b0; cfg_valid = 1'b1; cfg_data = 4'h9;
    #1;
    chk1("s5_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    chk1("s5_busy", busy, 1'b0);
    start = 1'b0; stop = 1'b0;
    any_strobe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_strobe = any_strobe | cnt_load | cnt_en | tc_pulse | busy;
    end
    chk1("s5_no_strobe", any_strobe, 1'b0);
    chk1("s5_underrun_kept", underrun, 1'b1);

    // Reset in the middle of a prescale period loses all state including FIFO.
    start = 1'b1;
    tick();
    chk1("s6_busy", busy, 1'b1);
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 4'h3;
    tick();
    chk1("s6_load", cnt_load, 1'b1);
    chk4("s6_load_d", cnt_d, 4'h9);
    cfg_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("s6_ready_in_rst", cfg_ready, 1'b0);
    tick();
    chk1("s6_rst_load", cnt_load, 1'b0);
    chk1("s6_rst_en", cnt_en, 1'b0);
    chk4("s6_rst_d", cnt_d, 4'h0);
    chk1("s6_rst_underrun", underrun, 1'b0);
    chk1("s6_rst_busy", busy, 1'b0);
    rst = 1'b1;
    #1;
    chk1("s6_ready_after", cfg_ready, 1'b1);
    start = 1'b1;
    tick();
    chk1("s6_start_ignored", busy, 1'b0);
    start = 1'b0;
    any_strobe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_strobe = any_strobe | cnt_load | cnt_en | busy;
    end
    chk1("s6_no_strobe", any_strobe, 1'b0);
    cfg_valid = 1'b1; cfg_data = 4'h6;
    tick();
    cfg_valid = 1'b0; start = 1'b1;
    tick();
    chk1("s6_restart_busy", busy, 1'b1);
    start = 1'b0;
    tick();
    chk1("s6_restart_load", cnt_load, 1'b1);
    chk4("s6_restart_d", cnt_d, 4'h6);

    // Randomized run against the behavioural model.
    for (int i = 0; i < 3000; i++) begin
      rst       = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 47) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_data  = 4'($urandom);
      #1;
      chk1("rnd_ready", cfg_ready, rst && (m_fifo.size() < DEPTH));
      model_clock(rst, start, stop, cfg_valid, cfg_data, q_r);
      tick();
      chk1("rnd_load", cnt_load, m_load);
      chk1("rnd_en", cnt_en, m_en);
      chk4("rnd_d", cnt_d, m_d);
      chk1("rnd_tc", tc_pulse, m_tc);
      chk1("rnd_underrun", underrun, m_und);
      chk1("rnd_busy", busy, m_mode != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
